// File: rtl/sklansky_approx_pipe.sv
// Pipelined approximate Sklansky adder: the low ke bits carry only their own generate, and bits >= ke use an exact prefix seeded by g[ke-1].
// Define AXPPA_ERR_MON_EN to add an exact shadow adder with the Err_flag / Err_count outputs.
module sklansky_approx_pipe #(
  parameter int WIDTH = 16,
  parameter int K_MAX = 6,
  parameter int PIPE  = 1,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Carry_in,
  input  logic             Approx_en,
  input  logic [KW-1:0]    Approx_k,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry_Out
`ifdef AXPPA_ERR_MON_EN
  ,
  output logic             Err_flag,
  output logic [15:0]      Err_count
`endif
);

  localparam int L    = $clog2(WIDTH);
  localparam int M    = (PIPE == 2) ? L / 2 : L;
  localparam int KLIM = (K_MAX < WIDTH) ? K_MAX : WIDTH;

  // One Sklansky level: bit i with bit lvl of i set absorbs the top bit of the lower half-block.
  function automatic logic [2*WIDTH-1:0] sk_level(input logic [WIDTH-1:0] g,
                                                  input logic [WIDTH-1:0] p,
                                                  input int lvl);
    logic [WIDTH-1:0] go;
    logic [WIDTH-1:0] po;
    int j;
    go = g;
    po = p;
    for (int i = 0; i < WIDTH; i++) begin
      if (((i >> lvl) & 1) == 1) begin
        j     = ((i >> lvl) << lvl) - 1;
        go[i] = g[i] | (p[i] & g[j]);
        po[i] = p[i] & p[j];
      end
    end
    return {go, po};
  endfunction

  logic [KW-1:0]    ke;
  logic [WIDTH-1:0] p_in, gm, pm, g_f, p_f;
  logic             cin_f;

  // Clearing propagate below ke makes the low carries bit-local and seeds bit ke with g[ke-1].
  always_comb begin
    ke = '0;
    if (Approx_en) ke = (Approx_k > KW'(KLIM)) ? KW'(KLIM) : Approx_k;
    p_in  = A ^ B;
    gm    = A & B;
    pm    = p_in;
    cin_f = (ke == '0) & Carry_in;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(ke)) pm[i] = 1'b0;
    end
    gm[0] = gm[0] | (p_in[0] & cin_f);
    g_f   = gm;
    p_f   = pm;
    for (int l = 0; l < M; l++) {g_f, p_f} = sk_level(g_f, p_f, l);
  end

`ifdef AXPPA_ERR_MON_EN
  logic [WIDTH:0] ex_f, ex_b;
  always_comb ex_f = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin_f};
`endif

  logic [WIDTH-1:0] g_b, p_b, praw_b;
  logic             cin_b, b_valid, out_full, adv_out;

  assign adv_out   = ~out_full | Out_ready;
  assign Out_valid = out_full;

  if (PIPE == 2) begin : g_mid
    logic             mid_full, mid_en, cin_r;
    logic [WIDTH-1:0] g_r, p_r, praw_r;
`ifdef AXPPA_ERR_MON_EN
    logic [WIDTH:0]   ex_r;
`endif
    assign mid_en = ~mid_full | adv_out;
    always_ff @(posedge clk) begin
      if (rst) begin
        mid_full <= 1'b0;
        g_r      <= '0;
        p_r      <= '0;
        praw_r   <= '0;
        cin_r    <= 1'b0;
`ifdef AXPPA_ERR_MON_EN
        ex_r     <= '0;
`endif
      end else if (mid_en) begin
        mid_full <= In_valid;
        if (In_valid) begin
          g_r    <= g_f;
          p_r    <= p_f;
          praw_r <= p_in;
          cin_r  <= cin_f;
`ifdef AXPPA_ERR_MON_EN
          ex_r   <= ex_f;
`endif
        end
      end
    end
    assign In_ready = mid_en;
    assign b_valid  = mid_full;
    assign g_b      = g_r;
    assign p_b      = p_r;
    assign praw_b   = praw_r;
    assign cin_b    = cin_r;
`ifdef AXPPA_ERR_MON_EN
    assign ex_b     = ex_r;
`endif
  end else begin : g_nomid
    assign In_ready = adv_out;
    assign b_valid  = In_valid;
    assign g_b      = g_f;
    assign p_b      = p_f;
    assign praw_b   = p_in;
    assign cin_b    = cin_f;
`ifdef AXPPA_ERR_MON_EN
    assign ex_b     = ex_f;
`endif
  end

  logic [WIDTH-1:0] g_o, p_o, sum_c;
  logic             cout_c;

  always_comb begin
    g_o = g_b;
    p_o = p_b;
    for (int l = M; l < L; l++) {g_o, p_o} = sk_level(g_o, p_o, l);
    sum_c  = praw_b ^ {g_o[WIDTH-2:0], cin_b};
    cout_c = g_o[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_full  <= 1'b0;
      Sum       <= '0;
      Carry_Out <= 1'b0;
    end else if (adv_out) begin
      out_full <= b_valid;
      if (b_valid) begin
        Sum       <= sum_c;
        Carry_Out <= cout_c;
      end
    end
  end

`ifdef AXPPA_ERR_MON_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      Err_flag  <= 1'b0;
      Err_count <= '0;
    end else begin
      if (adv_out && b_valid) Err_flag <= ({cout_c, sum_c} != ex_b);
      if (out_full && Out_ready && Err_flag && (Err_count != 16'hFFFF))
        Err_count <= Err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sklansky_approx_pipe.sv
// Bench for sklansky_approx_pipe (WIDTH=16, K_MAX=6, PIPE=2): directed table, backpressure, random and clamp streams, mid-op reset.
module tb_sklansky_approx_pipe;
  localparam int WIDTH = 16;
  localparam int K_MAX = 6;
  localparam int PIPE  = 2;
  localparam int KW    = 5;

  logic clk = 1'b0;
  logic rst;
  logic In_valid, In_ready, Carry_in, Approx_en, Out_valid, Out_ready, Carry_Out;
  logic [WIDTH-1:0] A, B, Sum;
  logic [KW-1:0] Approx_k;
`ifdef AXPPA_ERR_MON_EN
  logic Err_flag;
  logic [15:0] Err_count;
`endif

  always #5 clk = ~clk;

  sklansky_approx_pipe #(.WIDTH(WIDTH), .K_MAX(K_MAX), .PIPE(PIPE), .KW(KW)) dut (
    .clk(clk), .rst(rst), .In_valid(In_valid), .In_ready(In_ready), .A(A), .B(B),
    .Carry_in(Carry_in), .Approx_en(Approx_en), .Approx_k(Approx_k),
    .Out_valid(Out_valid), .Out_ready(Out_ready), .Sum(Sum), .Carry_Out(Carry_Out)
`ifdef AXPPA_ERR_MON_EN
    , .Err_flag(Err_flag), .Err_count(Err_count)
`endif
  );

  typedef struct {
    logic [15:0] a, b;
    logic cin, en;
    logic [4:0] k;
    logic [15:0] sum;
    logic cout, err;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic cout, err;
  } exp_t;

  vec_t vecs[8];
  exp_t q[$];
  int n_chk = 0, n_pass = 0, rx_cnt = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Reference: the exact region is an ordinary integer add of the upper operand slices plus g[ke-1].
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic en, input logic [4:0] k);
    exp_t r;
    int ke;
    int unsigned ai, bi, ex, res, hi, lo;
    ai = 32'(a);
    bi = 32'(b);
    ke = en ? ((int'(k) > K_MAX) ? K_MAX : int'(k)) : 0;
    ex = ai + bi + ((ke == 0) ? 32'(cin) : 32'd0);
    if (ke == 0) res = ex;
    else begin
      hi  = (ai >> ke) + (bi >> ke) + (((ai & bi) >> (ke - 1)) & 32'd1);
      lo  = ((ai ^ bi) ^ ((ai & bi) << 1)) & ((32'd1 << ke) - 32'd1);
      res = (hi << ke) | lo;
    end
    r.sum  = res[15:0];
    r.cout = res[16];
    r.err  = (res[16:0] != ex[16:0]);
    return r;
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (Out_valid && Out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: got output 0x%0h with no beat outstanding, expected none", Sum);
      end else begin
        e = q.pop_front();
        chk("sb_sum", 32'(Sum), 32'(e.sum));
        chk("sb_cout", 32'(Carry_Out), 32'(e.cout));
`ifdef AXPPA_ERR_MON_EN
        chk("sb_err_flag", 32'(Err_flag), 32'(e.err));
`endif
        if (e.err && exp_cnt != 16'hFFFF) exp_cnt++;
        rx_cnt++;
      end
    end
    if (In_valid && In_ready) q.push_back(model(A, B, Carry_in, Approx_en, Approx_k));
  endtask

  task automatic drive(input vec_t v);
    A = v.a; B = v.b; Carry_in = v.cin; Approx_en = v.en; Approx_k = v.k;
  endtask

  task automatic drain();
    for (int w = 0; w < 50 && q.size() > 0; w++) begin
      Out_ready = 1'b1;
      tick();
      @(posedge clk); #1;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic run_stream(input int n, input bit k15, input bit rand_rdy);
    int sent = 0;
    bit hold = 1'b0;
    for (int c = 0; c < 20 * n + 100 && sent < n; c++) begin
      if (!hold) begin
        In_valid = ($urandom_range(0, 4) != 0);
        A = 16'($urandom);
        B = ($urandom_range(0, 3) == 0) ? ~A : 16'($urandom);
        Carry_in  = 1'($urandom);
        Approx_en = k15 ? 1'b1 : 1'($urandom);
        Approx_k  = k15 ? 5'd15 : 5'($urandom_range(0, 16));
      end
      Out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      if (In_valid && In_ready) sent++;
      hold = In_valid && !In_ready;
      @(posedge clk); #1;
    end
    chk("stream_sent", 32'(sent), 32'(n));
    In_valid = 1'b0;
    drain();
  endtask

  task automatic wait_out(input string name, output int lat);
    lat = 1;
    @(negedge clk);
    while (!Out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk(name, 32'(lat), 32'(PIPE));
  endtask

  initial begin
    int lat, sent, rx0;
    vec_t bp[8];
    vecs[0] = '{16'h003F, 16'h0001, 1'b0, 1'b1, 5'd6,  16'h003C, 1'b0, 1'b1};
    vecs[1] = '{16'hFFC0, 16'h0040, 1'b0, 1'b1, 5'd6,  16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 5'd6,  16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'hFFFF, 16'h0000, 1'b1, 1'b1, 5'd6,  16'hFFFF, 1'b0, 1'b0};
    vecs[4] = '{16'h003F, 16'h0001, 1'b0, 1'b1, 5'd15, 16'h003C, 1'b0, 1'b1};
    vecs[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 5'd3,  16'h5555, 1'b0, 1'b0};
    vecs[6] = '{16'h0003, 16'h0001, 1'b0, 1'b1, 5'd2,  16'h0000, 1'b0, 1'b1};
    vecs[7] = '{16'h00FF, 16'h0001, 1'b1, 1'b1, 5'd0,  16'h0101, 1'b0, 1'b0};

    rst = 1'b1; In_valid = 1'b0; Out_ready = 1'b0;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(Out_valid), 32'd0);
    chk("rst_sum", 32'(Sum), 32'd0);
    chk("rst_cout", 32'(Carry_Out), 32'd0);
    chk("rst_in_ready", 32'(In_ready), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i]);
      In_valid = 1'b1; Out_ready = 1'b1;
      @(posedge clk); #1 In_valid = 1'b0;
      wait_out("vec_latency", lat);
      chk("vec_sum", 32'(Sum), 32'(vecs[i].sum));
      chk("vec_cout", 32'(Carry_Out), 32'(vecs[i].cout));
`ifdef AXPPA_ERR_MON_EN
      chk("vec_err_flag", 32'(Err_flag), 32'(vecs[i].err));
`endif
      if (vecs[i].err) exp_cnt++;
      @(posedge clk); #1;
    end
`ifdef AXPPA_ERR_MON_EN
    chk("vec_err_count", 32'(Err_count), 32'(exp_cnt));
`endif

    // Backpressure: Out_ready low in cycles 3..6 of an 8-beat burst.
    for (int i = 0; i < 8; i++)
      bp[i] = '{16'(i * 16'h1111 + 16'h0101), 16'(16'h00F0 + i), 1'(i), 1'(i >> 1), 5'(i + 3),
                16'h0, 1'b0, 1'b0};
    sent = 0;
    rx0 = rx_cnt;
    for (int c = 0; c < 40 && (sent < 8 || q.size() > 0); c++) begin
      Out_ready = !(c >= 3 && c <= 6);
      if (sent < 8) begin
        drive(bp[sent]);
        In_valid = 1'b1;
      end else In_valid = 1'b0;
      tick();
      if (c == 5) begin
        chk("bp_in_ready_low", 32'(In_ready), 32'd0);
        chk("bp_out_valid_held", 32'(Out_valid), 32'd1);
      end
      if (In_valid && In_ready) sent++;
      @(posedge clk); #1;
    end
    In_valid = 1'b0;
    chk("bp_sent", 32'(sent), 32'd8);
    chk("bp_received", 32'(rx_cnt - rx0), 32'd8);

    run_stream(400, 1'b0, 1'b1);
    run_stream(1000, 1'b1, 1'b0);
`ifdef AXPPA_ERR_MON_EN
    chk("stream_err_count", 32'(Err_count), 32'(exp_cnt));
`endif

    // Fill the pipe under stall, then reset mid-operation.
    Out_ready = 1'b0;
    drive(vecs[1]); In_valid = 1'b1;
    @(posedge clk); #1;
    drive(vecs[2]);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_out_valid", 32'(Out_valid), 32'd1);
    chk("full_in_ready", 32'(In_ready), 32'd0);
    @(posedge clk); #1;
    In_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    q.delete();
    exp_cnt = 16'd0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(Out_valid), 32'd0);
    chk("mid_rst_sum", 32'(Sum), 32'd0);
    chk("mid_rst_cout", 32'(Carry_Out), 32'd0);
    chk("mid_rst_in_ready", 32'(In_ready), 32'd1);
`ifdef AXPPA_ERR_MON_EN
    chk("mid_rst_err_count", 32'(Err_count), 32'd0);
`endif
    @(posedge clk); #1;
    drive(vecs[0]); In_valid = 1'b1; Out_ready = 1'b1;
    @(posedge clk); #1 In_valid = 1'b0;
    wait_out("post_rst_latency", lat);
    chk("post_rst_sum", 32'(Sum), 32'h003C);
    chk("post_rst_cout", 32'(Carry_Out), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_no_dup", 32'(Out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
